pool2x2_stream: RTL and testbench
=================================

# pool2x2_stream

Streaming 2×2 pooling engine that replaces the purely combinational second-largest pooler with a parametrised, handshaked, line-buffered block. It consumes one raster-order colour plane (IMG_W × IMG_H pixels of DATA_W bits) and emits one pooled (IMG_W/2 × IMG_H/2) plane. A run-time mode selects max, second-largest, min or average pooling. It sits between the pixel loader and the output writer, and it processes channels as consecutive frames.

## Interface
- DATA_W, 4: pixel width in bits.
- IMG_W, 180: input plane width. Must be even and ≥2; any other value is an elaboration error.
- IMG_H, 180: input plane height. Must be even and ≥2; any other value is an elaboration error.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  pooling mode: 0 max, 1 second-largest, 2 min, 3 average.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  DATA_W  input pixel, raster order, row-major.
- m_valid  out  1  pooled pixel valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  DATA_W  pooled pixel.
- m_last  out  1  high with the final pooled pixel of a frame.

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted beat.
  - col wraps to 0 at IMG_W-1 and row increments.
  - row wraps to 0 at IMG_H-1 with col wrap; the next beat starts a new frame.
- Even rows: the accepted pixel is written to linebuf[col]. The line buffer holds IMG_W × DATA_W bits and is not reset.
- Odd rows, even col: the pixel is stored in hold register `left`.
- Odd rows, odd col: the window is a = linebuf[col-1], b = linebuf[col], c = left, d = s_data. The result is registered into m_data.
- Mode rules:
  - max: the largest of the four.
  - second-largest: sort descending and take index 1, with duplicates counted ({5,5,3,1} → 5).
  - min: the smallest of the four.
  - average: (a+b+c+d) >> 2, using a DATA_W+2-bit sum and truncation.
- mode is latched on the first accepted beat of each frame (row = 0, col = 0) and used for the whole frame. Changes mid-frame take effect at the next frame.
- m_last = 1 for the output produced at row = IMG_H-1, col = IMG_W-1.
- Output register:
  - m_valid sets on a producing beat.
  - m_valid clears on m_valid && m_ready unless a new producing beat occurs in the same cycle, in which case the register reloads and stays valid.
- s_ready = !m_valid || m_ready, combinational. A producing beat is therefore never lost, and non-producing beats are also stalled while the output is stuck.

## Timing
- Reset values: m_valid 0, m_data 0, m_last 0, col 0, row 0, left 0, latched mode 0. s_ready is 1 out of reset.
- rst asserted mid-frame aborts the frame: counters return to 0 and any pending output is discarded. The next accepted pixel is (0,0) of a new frame.
- Latency: m_valid rises on the clock edge that accepts the pixel at (odd row, odd col). Data is visible the same cycle m_valid is high, one cycle after acceptance.
- Throughput: one pixel per cycle in; one output per four inputs. With m_ready tied high there are no stalls.
- While m_valid && !m_ready:
  - m_data and m_last are held stable.
  - s_ready = 0; counters and buffers are frozen.
- Gaps in s_valid are allowed anywhere; state advances only on accepted beats.

## Configuration
- POOL_AVG_EN defined: mode 3 computes the average using the adder tree.
- POOL_AVG_EN undefined: the adder is not built and mode 3 behaves exactly as mode 0 (max).
- Modes 0–2 are identical in both builds.

## Test plan
All scenarios use IMG_W=4, IMG_H=4, DATA_W=4, with m_ready=1 unless stated. The top-left window is rows 0–1, cols 0–1 = {9,3,7,7}.
- Modes 0, 1, 2 and 3 (POOL_AVG_EN defined) over four frames → top-left outputs 9, 7, 3 and 6. Without POOL_AVG_EN, mode 3 → 9.
- Window {5,5,3,1} in mode 1 → 5. Window {2,2,2,2} in modes 0–3 → 2.
- Full frame of 16 beats → exactly 4 outputs, in order (0,0), (0,1), (1,0), (1,1). m_last is high only on the 4th output; a second back-to-back frame gives the same results.
- m_ready held 0 for 5 cycles after the first output → s_ready = 0 and m_data stable. On release, all outputs are still correct and none are duplicated.
- mode switched 0→2 after beat 3 of a frame → that frame is pooled as max; the following frame is pooled as min.
- rst pulsed after 6 accepted beats, then a fresh 16-beat frame → m_valid = 0 immediately, followed by 4 correct outputs with m_last on the 4th.

Source files
------------

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 pooling engine (max / second-largest / min / average) with a
// one-line buffer and a valid/ready output register. Optional macro: POOL_AVG_EN.
module pool2x2_stream #(
  parameter int DATA_W = 4,
  parameter int IMG_W  = 180,
  parameter int IMG_H  = 180
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  if ((IMG_W < 2) || (IMG_W % 2 != 0)) begin : g_bad_img_w
    $error("pool2x2_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_img_h
    $error("pool2x2_stream: IMG_H must be even and >= 2");
  end

  localparam int CW = ($clog2(IMG_W) > 0) ? $clog2(IMG_W) : 1;
  localparam int RW = ($clog2(IMG_H) > 0) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    return (x < y) ? x : y;
  endfunction

`ifdef POOL_AVG_EN
  function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c,
                                             input logic [DATA_W-1:0] d);
    logic [DATA_W+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[DATA_W+1:2];
  endfunction
`endif

  // Pairwise split: the runner-up is either the loser of the two pair winners
  // or the best of the two pair losers, which counts duplicates correctly.
  function automatic logic [DATA_W-1:0] pool4(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c,
                                              input logic [DATA_W-1:0] d,
                                              input logic [1:0]        md);
    logic [DATA_W-1:0] hi_ab, lo_ab, hi_cd, lo_cd, res;
    hi_ab = max2(a, b);
    lo_ab = min2(a, b);
    hi_cd = max2(c, d);
    lo_cd = min2(c, d);
    case (md)
      2'd1:    res = max2(min2(hi_ab, hi_cd), max2(lo_ab, lo_cd));
      2'd2:    res = min2(lo_ab, lo_cd);
`ifdef POOL_AVG_EN
      2'd3:    res = avg4(a, b, c, d);
`endif
      default: res = max2(hi_ab, hi_cd);
    endcase
    return res;
  endfunction

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [1:0]        mode_q, mode_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W-1:0] lb_q [IMG_W];

  logic              accept, first_beat, produce;
  logic [1:0]        mode_eff;
  logic [DATA_W-1:0] pool_res;

  assign s_ready    = !m_valid_q || m_ready;
  assign accept     = s_valid && s_ready;
  assign first_beat = (row_q == '0) && (col_q == '0);
  assign produce    = accept && row_q[0] && col_q[0];
  assign mode_eff   = first_beat ? mode : mode_q;
  assign pool_res   = pool4(lb_q[col_q - CW'(1)], lb_q[col_q], left_q, s_data, mode_eff);

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    left_d    = left_q;
    mode_d    = mode_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (accept) begin
      if (first_beat) begin
        mode_d = mode;
      end
      if (row_q[0] && !col_q[0]) begin
        left_d = s_data;
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (produce) begin
      m_valid_d = 1'b1;
      m_data_d  = pool_res;
      m_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      left_q    <= '0;
      mode_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      left_q    <= left_d;
      mode_q    <= mode_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  // Line buffer carries no reset; every even-row entry is rewritten before use.
  always_ff @(posedge clk) begin
    if (accept && !row_q[0]) begin
      lb_q[col_q] <= s_data;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream on a 4x4 plane with 4-bit pixels.
module tb_pool2x2_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] s_data = 4'd0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [3:0] m_data;
  logic       m_last;

  int checks = 0;
  int errors = 0;
  int nout   = 0;

  logic [4:0] exp_q[$];
  logic [3:0] pix[16];

  pool2x2_stream #(.DATA_W(4), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [3:0] w0, input logic [3:0] w1,
                                       input logic [3:0] w2, input logic [3:0] w3,
                                       input logic [1:0] md);
    logic [3:0] s[4];
    logic [3:0] t;
    int sum;
    s[0] = w0; s[1] = w1; s[2] = w2; s[3] = w3;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (s[j] < s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    sum = int'(w0) + int'(w1) + int'(w2) + int'(w3);
    case (md)
      2'd0: return s[0];
      2'd1: return s[1];
      2'd2: return s[3];
`ifdef POOL_AVG_EN
      default: return 4'(sum / 4);
`else
      default: return (sum >= 0) ? s[0] : 4'd0;
`endif
    endcase
  endfunction

  // Output monitor: pops one expected entry per handshake.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      nout++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%0d last=%0b, required none", m_data, m_last);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({m_last, m_data} !== e) begin
          errors++;
          $display("FAIL output: got data=%0d last=%0b, required data=%0d last=%0b",
                   m_data, m_last, e[3:0], e[4]);
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [1:0] md);
    int r, c;
    r = i / 4; c = i % 4;
    if (r % 2 == 1 && c % 2 == 1)
      exp_q.push_back({(r == 3 && c == 3),
                       model(pix[(r-1)*4+c-1], pix[(r-1)*4+c], pix[r*4+c-1], pix[r*4+c], md)});
  endtask

  task automatic send_pix(input logic [3:0] p);
    int n;
    logic acc;
    s_valid = 1'b1; s_data = p; n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: got s_ready=0 for 50 cycles, required acceptance");
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) pix[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic send_frame(input int sw_beat, input logic [1:0] sw_mode);
    logic [1:0] fmode;
    fmode = mode;
    for (int i = 0; i < 16; i++) begin
      if (i == sw_beat) mode = sw_mode;
      if (i == 0) fmode = mode;
      push_exp(i, fmode);
      send_pix(pix[i]);
    end
  endtask

  task automatic check_frame_done(input int n0, input string tag);
    drain();
    checks++;
    if (nout - n0 !== 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs (%0d pending), required 4 (0 pending)",
               tag, nout - n0, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({m_valid, m_data, m_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d last=%0b, required 0/0/0", m_valid, m_data, m_last);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready: got %0b, required 1", s_ready);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_m_valid: got %0b, required 0", m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    int n0;
    for (int m = 0; m < 4; m++) begin
      rand_frame();
      pix[0] = 4'd9; pix[1] = 4'd3; pix[4] = 4'd7; pix[5] = 4'd7;
      mode = 2'(m);
      n0 = nout;
      send_frame(-1, 2'd0);
      check_frame_done(n0, "modes");
    end
  endtask

  task automatic test_special_windows();
    int n0;
    for (int m = 0; m < 4; m++) begin
      rand_frame();
      pix[0] = 4'd5; pix[1] = 4'd5; pix[4] = 4'd3; pix[5] = 4'd1;
      pix[2] = 4'd2; pix[3] = 4'd2; pix[6] = 4'd2; pix[7] = 4'd2;
      pix[8] = 4'd15; pix[9] = 4'd0; pix[12] = 4'd15; pix[13] = 4'd15;
      mode = 2'(m);
      n0 = nout;
      send_frame(-1, 2'd0);
      check_frame_done(n0, "special");
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    rand_frame();
    mode = 2'd1;
    n0 = nout;
    send_frame(-1, 2'd0);
    send_frame(-1, 2'd0);
    drain();
    checks++;
    if (nout - n0 !== 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d outputs, required 8", nout - n0);
    end
  endtask

  task automatic test_stall();
    int n0;
    logic [3:0] held;
    rand_frame();
    mode = 2'd0;
    n0 = nout;
    for (int i = 0; i < 6; i++) begin
      push_exp(i, 2'd0);
      send_pix(pix[i]);
    end
    m_ready = 1'b0;
    held = exp_q[0][3:0];
    s_valid = 1'b1; s_data = pix[6];
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== held) begin
        errors++;
        $display("FAIL stall_hold: got s_ready=%0b valid=%0b data=%0d, required 0/1/%0d",
                 s_ready, m_valid, m_data, held);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 6; i < 16; i++) begin
      push_exp(i, 2'd0);
      send_pix(pix[i]);
    end
    check_frame_done(n0, "stall");
  endtask

  task automatic test_mode_switch();
    int n0;
    rand_frame();
    mode = 2'd0;
    n0 = nout;
    send_frame(4, 2'd2);
    check_frame_done(n0, "switch_max");
    rand_frame();
    n0 = nout;
    send_frame(-1, 2'd0);
    check_frame_done(n0, "switch_min");
  endtask

  task automatic test_reset_mid();
    int n0;
    rand_frame();
    mode = 2'd2;
    for (int i = 0; i < 6; i++) send_pix(pix[i]);
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %0b, required 0", m_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rand_frame();
    mode = 2'd0;
    n0 = nout;
    send_frame(-1, 2'd0);
    check_frame_done(n0, "reset_mid");
  endtask

  initial begin
    test_reset();
    test_modes();
    test_special_windows();
    test_back_to_back();
    test_stall();
    test_mode_switch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
